// File: rtl/pulse_train_if.sv
// pulse_train_if
//   Groups the control inputs and LED/status outputs of pulse_train into one
//   bundle. The game controller side uses the master modport, the pulser
//   itself uses the slave modport.
//
//   start       : begin a train (taken only when the pulser is idle)
//   abort       : terminate an active train
//   pattern     : lights shown during ON phases
//   on_units    : ON duration in time units (0 behaves as 1)
//   off_units   : OFF duration in time units (0 behaves as 1)
//   repeats     : number of pulses, 0..15
//   mode        : 0 = fixed pattern, 1 = rotate left after every pulse
//   lights      : LED drive
//   busy        : high while a train is in its ON/OFF phases
//   done        : one-cycle completion pulse
//   pulse_index : index of the current pulse, 0 outside ON/OFF
interface pulse_train_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [7:0]       on_units;
  logic [7:0]       off_units;
  logic [3:0]       repeats;
  logic             mode;
  logic [WIDTH-1:0] lights;
  logic             busy;
  logic             done;
  logic [3:0]       pulse_index;

  modport master (
    output start, abort, pattern, on_units, off_units, repeats, mode,
    input  lights, busy, done, pulse_index
  );

  modport slave (
    input  start, abort, pattern, on_units, off_units, repeats, mode,
    output lights, busy, done, pulse_index
  );
endinterface

// File: rtl/pulse_train.sv
// pulse_train
//   Lamp pulser. On start it latches a light pattern and timing settings,
//   then alternates ON (pattern shown) and OFF (all dark) phases for the
//   requested number of pulses, optionally rotating the pattern left after
//   every pulse to form a chase. A one-cycle done pulse closes every train,
//   whether it ran to completion or was aborted.
//
//   clock : single clock, everything on the rising edge
//   reset : synchronous, active-high; returns to IDLE with all state cleared
//   bus   : pulse_train_if slave modport (controls in, lights/status out)
//
//   Timing is built from a prescaler that produces one unit tick every
//   TICKS_PER_UNIT cycles and an 8-bit unit counter compared against the
//   latched duration of the current phase. Both counters restart on every
//   state change so each phase lasts exactly duration*TICKS_PER_UNIT cycles.
module pulse_train #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int WIDTH           = 10,
  parameter int TICKS_PER_UNIT  = CLOCK_FREQUENCY / 100
) (
  input  logic          clock,
  input  logic          reset,
  pulse_train_if.slave  bus
);

  // A one-bit prescaler is kept even for TICKS_PER_UNIT == 1; it then sits
  // at zero and every cycle is a unit tick.
  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_UNIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [7:0]       unit_reg,  unit_next;
  logic [3:0]       index_reg, index_next;
  logic [WIDTH-1:0] pat_reg,   pat_next;
  logic [7:0]       on_reg,    on_next;
  logic [7:0]       off_reg,   off_next;
  logic [3:0]       rep_reg,   rep_next;
  logic             mode_reg,  mode_next;

  logic [WIDTH-1:0] pat_rot;
  logic             unit_tick;
  logic [7:0]       phase_dur;
  logic             phase_end;
  logic [3:0]       index_inc;

  // Rotate-left-by-one wiring: bit gi takes bit gi-1, bit 0 takes the MSB.
  // The modulo form also covers a single-light build.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign pat_rot[gi] = pat_reg[(gi + WIDTH - 1) % WIDTH];
    end
  endgenerate

  assign unit_tick = (presc_reg == PRESC_MAX);
  assign phase_dur = (state_reg == OFF) ? off_reg : on_reg;
  // Latched durations are never zero, so dur-1 cannot underflow.
  assign phase_end = unit_tick && (unit_reg == (phase_dur - 8'd1));
  assign index_inc = index_reg + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      unit_reg  <= '0;
      index_reg <= '0;
      pat_reg   <= '0;
      on_reg    <= 8'd1;
      off_reg   <= 8'd1;
      rep_reg   <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      unit_reg  <= unit_next;
      index_reg <= index_next;
      pat_reg   <= pat_next;
      on_reg    <= on_next;
      off_reg   <= off_next;
      rep_reg   <= rep_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    pat_next   = pat_reg;
    on_next    = on_reg;
    off_next   = off_reg;
    rep_next   = rep_reg;
    mode_next  = mode_reg;
    // Free-running timing by default; any state change below clears it.
    presc_next = unit_tick ? '0 : presc_reg + 1'b1;
    unit_next  = unit_tick ? unit_reg + 8'd1 : unit_reg;

    case (state_reg)
      IDLE: begin
        presc_next = '0;
        unit_next  = '0;
        if (bus.start) begin
          pat_next   = bus.pattern;
          on_next    = (bus.on_units  == 8'd0) ? 8'd1 : bus.on_units;
          off_next   = (bus.off_units == 8'd0) ? 8'd1 : bus.off_units;
          rep_next   = bus.repeats;
          mode_next  = bus.mode;
          index_next = '0;
          state_next = (bus.repeats == 4'd0) ? DONE : ON;
        end
      end

      ON: begin
        // abort takes priority over a coincident phase end
        if (bus.abort) begin
          state_next = DONE;
          presc_next = '0;
          unit_next  = '0;
        end else if (phase_end) begin
          state_next = OFF;
          presc_next = '0;
          unit_next  = '0;
        end
      end

      OFF: begin
        if (bus.abort) begin
          state_next = DONE;
          presc_next = '0;
          unit_next  = '0;
        end else if (phase_end) begin
          presc_next = '0;
          unit_next  = '0;
          index_next = index_inc;
          if (index_inc == rep_reg) begin
            state_next = DONE;
          end else begin
            state_next = ON;
            if (mode_reg) begin
              pat_next = pat_rot;
            end
          end
        end
      end

      DONE: begin
        state_next = IDLE;
        presc_next = '0;
        unit_next  = '0;
        index_next = '0;
      end

      default: begin
        state_next = IDLE;
        presc_next = '0;
        unit_next  = '0;
      end
    endcase
  end

  // Outputs are decoded from registered state only; no input reaches them
  // combinationally.
  assign bus.lights      = (state_reg == ON) ? pat_reg : '0;
  assign bus.busy        = (state_reg == ON) || (state_reg == OFF);
  assign bus.done        = (state_reg == DONE);
  assign bus.pulse_index = bus.busy ? index_reg : 4'd0;

endmodule

// File: tb/tb_pulse_train.sv
// tb_pulse_train
//   Drives pulse_train with directed trains followed by randomized stimulus
//   and compares every output on every cycle against a reference model that
//   derives the expected outputs from the elapsed time since start.
module tb_pulse_train;
  localparam int W = 10;
  localparam int T = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pulse_train_if #(.WIDTH(W)) bus ();

  pulse_train #(
    .CLOCK_FREQUENCY(200),
    .WIDTH(W),
    .TICKS_PER_UNIT(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int last_k = 0;

  // reference model: 0 idle, 1 train running (incl. its done cycle), 2 aborted
  int m_phase = 0;
  int m_k, m_on, m_off, m_rep, m_per;
  logic [W-1:0] m_pat;
  bit m_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < n % W; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  // One clock edge: advance the model with the inputs sampled at the edge,
  // then compare all outputs 1 time unit later.
  task automatic tick();
    logic [W-1:0] e_l;
    int e_b, e_d, e_i, t;
    @(posedge clock);
    edge_n++;
    if (reset) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_pat  = bus.pattern;
          m_on   = (bus.on_units == 0) ? 1 : int'(bus.on_units);
          m_off  = (bus.off_units == 0) ? 1 : int'(bus.off_units);
          m_rep  = int'(bus.repeats);
          m_mode = bus.mode;
          m_per  = (m_on + m_off) * T;
          m_k    = edge_n;
          m_phase = 1;
        end
        1: begin
          t = edge_n - 1 - m_k;
          if (t == m_rep * m_per) m_phase = 0;
          else if (bus.abort) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    e_l = '0; e_b = 0; e_d = 0; e_i = 0;
    if (m_phase == 1) begin
      t = edge_n - m_k;
      if (t == m_rep * m_per) begin
        e_d = 1;
      end else begin
        e_b = 1;
        e_i = t / m_per;
        if ((t % m_per) < m_on * T) e_l = rotl(m_pat, m_mode ? e_i : 0);
      end
    end else if (m_phase == 2) begin
      e_d = 1;
    end
    #1;
    check("lights", 32'(bus.lights), 32'(e_l));
    check("busy", 32'(bus.busy), 32'(e_b));
    check("done", 32'(bus.done), 32'(e_d));
    check("pulse_index", 32'(bus.pulse_index), 32'(e_i));
    if (e_d != 0)
      $display("train end: edge=%0d start_edge=%0d aborted=%0d", edge_n, m_k, (m_phase == 2));
  endtask

  task automatic start_train(input logic [W-1:0] pat, input int on, input int off,
                             input int rep, input bit md);
    bus.pattern   = pat;
    bus.on_units  = 8'(on);
    bus.off_units = 8'(off);
    bus.repeats   = 4'(rep);
    bus.mode      = md;
    bus.start     = 1'b1;
    tick();
    last_k = edge_n;
    bus.start = 1'b0;
    // scramble settings mid-train; the latched copy must be unaffected
    bus.pattern   = W'($urandom);
    bus.on_units  = 8'($urandom);
    bus.off_units = 8'($urandom);
    bus.repeats   = 4'($urandom);
    bus.mode      = 1'($urandom);
  endtask

  // Ticks until done is seen (bounded), checks when it came, then one more
  // tick back into IDLE.
  task automatic expect_done_at(input string tag, input int want);
    int dt;
    dt = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.done) begin
        dt = edge_n - last_k;
        break;
      end
      tick();
    end
    check(tag, 32'(dt), 32'(want));
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pattern = '0;
    bus.on_units = '0; bus.off_units = '0; bus.repeats = '0; bus.mode = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // single pulse: done one cycle after 2 ON + 2 OFF cycles
    start_train(10'h010, 1, 1, 1, 1'b0);
    expect_done_at("t1_done_at", 4);

    // chase: 0x201, 0x003, 0x006
    start_train(10'h201, 2, 1, 3, 1'b1);
    expect_done_at("t2_done_at", 18);

    // zero repeats
    start_train(10'h3ff, 3, 3, 0, 1'b0);
    expect_done_at("t3_done_at", 0);

    // zero durations behave as one unit
    start_train(10'h155, 0, 0, 2, 1'b0);
    expect_done_at("t4_done_at", 8);

    // abort during the second ON, with start held high while busy
    start_train(10'h0f0, 2, 1, 4, 1'b0);
    bus.start = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_done", 32'(bus.done), 32'd1);
    check("abort_lights", 32'(bus.lights), 32'd0);
    tick();
    check("abort_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    check("abort_no_restart", 32'(bus.busy), 32'd0);

    // reset during OFF, then a full train
    start_train(10'h00f, 1, 2, 2, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_lights", 32'(bus.lights), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    start_train(10'h301, 1, 1, 2, 1'b1);
    expect_done_at("t6_done_at", 8);

    // randomized traffic, all checked by the model each cycle
    for (int c = 0; c < 4000; c++) begin
      bus.pattern   = W'($urandom);
      bus.on_units  = 8'($urandom_range(0, 3));
      bus.off_units = 8'($urandom_range(0, 3));
      bus.repeats   = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4));
      bus.mode      = 1'($urandom);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.abort     = ($urandom_range(0, 39) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pulse_train.md
# pulse_train

Parametrised lamp pulser, successor to the game's single half-second flash. On `start` it latches a `WIDTH`-bit light pattern and pulse settings, then shows the pattern for `on_units` time units and blanks for `off_units` units, repeating `repeats` times. Mode 1 rotates the pattern each pulse to produce a chase. It sits between the sequence-memory game controller and the LED bank, and replaces fixed-duration flashes with runtime-selectable timing and an abort path.

## Interface
- `CLOCK_FREQUENCY`, 50000000: clock rate in Hz.
- `WIDTH`, 10: number of lights.
- `TICKS_PER_UNIT`, CLOCK_FREQUENCY/100: clock cycles per time unit (10 ms at default). Must be ≥1.
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a train; sampled only in IDLE.
- `abort` in 1: terminate an active train.
- `pattern` in WIDTH: lights to show during ON phases.
- `on_units` in 8: ON duration in units; 0 treated as 1.
- `off_units` in 8: OFF duration in units; 0 treated as 1.
- `repeats` in 4: number of pulses, 0..15.
- `mode` in 1: 0 = same pattern every pulse; 1 = rotate left by one after each pulse.
- `lights` out WIDTH: LED drive.
- `busy` out 1: high in ON/OFF.
- `done` out 1: one-cycle completion pulse.
- `pulse_index` out 4: index of the current pulse; 0 outside ON/OFF.

## Operation
- States: IDLE, ON, OFF, DONE.
- **IDLE**
  - `start`=1 latches `pattern`, `on_units`, `off_units` (zero→1), `repeats` and `mode`, and clears both counters.
  - Next state is DONE if `repeats`=0, else ON.
- **ON**
  - `lights` = latched pattern.
  - Duration: exactly on_units×TICKS_PER_UNIT cycles, then OFF.
- **OFF**
  - `lights` = 0.
  - Duration: exactly off_units×TICKS_PER_UNIT cycles.
  - At the end of OFF: increment `pulse_index`. If it now equals `repeats`, go to DONE. Else go to ON, and if `mode`=1 rotate the latched pattern left by 1 (MSB→bit 0).
- **DONE**: `done`=1 and `lights`=0 for one cycle, then IDLE.
- **Counters**: prescaler counts 0..TICKS_PER_UNIT-1 and wraps, generating a unit tick. The 8-bit unit counter compares against the latched duration. Both counters clear on every state entry.
- **Input latching**: inputs other than `start`/`abort` are ignored outside IDLE. Changing them mid-train has no effect.
- `start` while busy or in DONE: ignored.
- `abort` in ON or OFF: next state DONE. `lights`=0 from the next cycle and `done` pulses. `abort` in IDLE or DONE: ignored.
- `abort` and a phase-end in the same cycle: `abort` wins (go to DONE).
- **Reset**, including mid-train: state IDLE; `lights`=0, `busy`=0, `done`=0, `pulse_index`=0; counters and latched pattern cleared. Takes effect the cycle after `reset` is sampled high.

## Timing
- `start` sampled at edge k:
  - `lights` shows the pattern from cycle k+1.
  - First ON cycles are k+1 .. k+on×T (T = TICKS_PER_UNIT).
- `done` is high in cycle k+1+repeats×(on+off)×T; IDLE is re-entered the following cycle. A new `start` is accepted from that IDLE cycle.
- `repeats`=0: `done` is high in cycle k+1, and `lights` never leaves 0.
- `abort` sampled at edge j: `done` is high in cycle j+1 and `busy`=0 in that cycle.
- `busy` is high exactly when the state is ON or OFF.
- `lights`, `busy` and `done` are registered or decoded purely from state; there is no combinational path from inputs to outputs.

## Test plan
- T=2, WIDTH=10, pattern=10'b0000010000, on=1, off=1, repeats=1, mode=0, start at k.
  - `lights` = 0x010 in cycles k+1..k+2 and 0 in k+3..k+4.
  - `done` high in cycle k+5 only.
- T=2, pattern=10'b1000000001, on=2, off=1, repeats=3, mode=1.
  - Successive ON patterns: 0x201, 0x003, 0x006.
  - Each ON lasts 4 cycles and each OFF 2 cycles.
  - `pulse_index` reads 0, 1, 2.
  - `done` high at k+19.
- `repeats`=0: `done` high at k+1; `lights` stays 0; `busy` never high.
- on=0, off=0, repeats=2, T=2: behaves as on=1/off=1; `done` at k+9.
- Abort during second ON of a repeats=4 train:
  - `lights`=0 and `done`=1 the next cycle, then IDLE.
  - A `start` issued while busy produces no restart.
- `reset` asserted mid-OFF: all outputs 0 the next cycle. A subsequent `start` runs a full, correctly timed train.
